// File: rtl/cam_pkg.sv
// Purpose : shared types and default frame geometry for the camera capture path.
// Latency : n/a (package only).
// Backpressure: n/a; the default geometry is also used by the DVS/CDMA BRAM addressing.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VSYNC  = 2'd1,
        ACTIVE = 2'd2
    } cam_state_t;

    localparam int CAM_H_RES = 320;
    localparam int CAM_V_RES = 240;

endpackage

// File: rtl/cam_sync_edge.sv
// Purpose : registers the raw camera pins once and derives vsync/href edge pulses.
// Latency : 1 pclk from pin to vs_r/hr_r/d_r; edge pulses are combinational on the registered copies.
// Backpressure: none; the camera cannot be stalled.
// Ports   : cam_vsync/cam_href/cam_data in; vs_r/hr_r/d_r registered copies; vs_rise, hr_rise, hr_fall pulses.
module cam_sync_edge (
    input  logic       pclk,
    input  logic       reset,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       vs_r,
    output logic       hr_r,
    output logic [7:0] d_r,
    output logic       vs_rise,
    output logic       hr_rise,
    output logic       hr_fall
);

    logic vs_r_d;
    logic hr_r_d;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vs_r   <= 1'b0;
            hr_r   <= 1'b0;
            d_r    <= 8'd0;
            vs_r_d <= 1'b0;
            hr_r_d <= 1'b0;
        end else begin
            vs_r   <= cam_vsync;
            hr_r   <= cam_href;
            d_r    <= cam_data;
            vs_r_d <= vs_r;
            hr_r_d <= hr_r;
        end
    end

    assign vs_rise = vs_r & ~vs_r_d;
    assign hr_rise = hr_r & ~hr_r_d;
    assign hr_fall = ~hr_r & hr_r_d;

endmodule

// File: rtl/cam_pixel_capture.sv
// Purpose : extracts the luma byte of each YUV422 pixel from an OV7670-style stream, with row/col and error flags.
// Latency : luma byte driven before edge k+1 is sampled at k+1 and appears on pix_data with pix_valid at edge k+2.
// Backpressure: none; pix_valid is a one-cycle strobe that the downstream stage must accept.
// Ports   : pclk, reset (async active-low), enable, cam_vsync/cam_href/cam_data in;
//           pix_data/pix_valid/col/row, frame_start, frame_cnt, busy, err_long/err_short out.
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_RES   = CAM_H_RES,
    parameter int V_RES   = CAM_V_RES,
    parameter bit Y_FIRST = 1'b1
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [7:0]               cam_data,
    output logic [7:0]               pix_data,
    output logic                     pix_valid,
    output logic                     frame_start,
    output logic [$clog2(H_RES)-1:0] col,
    output logic [$clog2(V_RES)-1:0] row,
    output logic [7:0]               frame_cnt,
    output logic                     busy,
    output logic                     err_long,
    output logic                     err_short
);

    localparam int CW  = $clog2(H_RES);
    localparam int RW  = $clog2(V_RES);
    // Internal counters must be able to hold H_RES / V_RES themselves (end-of-line / end-of-frame).
    localparam int CCW = $clog2(H_RES + 1);
    localparam int RCW = $clog2(V_RES + 1);
    localparam logic [CCW-1:0] H_LIM = CCW'(H_RES);
    localparam logic [RCW-1:0] V_LIM = RCW'(V_RES);
    localparam logic LUMA_PHASE = Y_FIRST ? 1'b0 : 1'b1;

    logic       vs_r, hr_r, vs_rise, hr_rise, hr_fall;
    logic [7:0] d_r;

    cam_sync_edge u_sync (
        .pclk      (pclk),
        .reset     (reset),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .vs_r      (vs_r),
        .hr_r      (hr_r),
        .d_r       (d_r),
        .vs_rise   (vs_rise),
        .hr_rise   (hr_rise),
        .hr_fall   (hr_fall)
    );

    cam_state_t     state, state_nx;
    logic           phase, phase_nx;
    logic [CCW-1:0] col_cnt, col_cnt_nx;
    logic [RCW-1:0] row_cnt, row_cnt_nx;
    logic [7:0]     pix_data_nx, frame_cnt_nx;
    logic           pix_valid_nx, frame_start_nx, busy_nx, err_long_nx, err_short_nx;
    logic [CW-1:0]  col_nx;
    logic [RW-1:0]  row_nx;
    logic           start_frame, set_long, set_short;
    logic [CCW-1:0] eff_col;
    logic           eff_phase;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            phase       <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            pix_data    <= 8'd0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_cnt   <= 8'd0;
            busy        <= 1'b0;
            err_long    <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            col_cnt     <= col_cnt_nx;
            row_cnt     <= row_cnt_nx;
            pix_data    <= pix_data_nx;
            pix_valid   <= pix_valid_nx;
            frame_start <= frame_start_nx;
            col         <= col_nx;
            row         <= row_nx;
            frame_cnt   <= frame_cnt_nx;
            busy        <= busy_nx;
            err_long    <= err_long_nx;
            err_short   <= err_short_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        phase_nx       = phase;
        col_cnt_nx     = col_cnt;
        row_cnt_nx     = row_cnt;
        pix_data_nx    = pix_data;
        pix_valid_nx   = 1'b0;
        frame_start_nx = 1'b0;
        col_nx         = col;
        row_nx         = row;
        frame_cnt_nx   = frame_cnt;
        busy_nx        = busy;
        err_long_nx    = err_long;
        err_short_nx   = err_short;
        start_frame    = 1'b0;
        set_long       = 1'b0;
        set_short      = 1'b0;
        // On the first href cycle of a line the stored col/phase are stale; use the cleared values.
        eff_col        = hr_rise ? '0 : col_cnt;
        eff_phase      = hr_rise ? 1'b0 : phase;

        case (state)
            IDLE: begin
                if (vs_rise && enable) start_frame = 1'b1;
            end
            VSYNC: begin
                if (!vs_r) state_nx = ACTIVE;
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Premature vsync: the frame was cut short.
                    if (hr_r || (row_cnt < V_LIM)) set_short = 1'b1;
                    if (enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end
                end else if (!vs_r) begin
                    if (hr_r) begin
                        phase_nx   = ~eff_phase;
                        col_cnt_nx = eff_col;
                        if (eff_phase == LUMA_PHASE) begin
                            if (eff_col < H_LIM) begin
                                pix_data_nx  = d_r;
                                pix_valid_nx = 1'b1;
                                col_nx       = eff_col[CW-1:0];
                                row_nx       = row_cnt[RW-1:0];
                                col_cnt_nx   = eff_col + CCW'(1);
                            end else begin
                                set_long = 1'b1;
                            end
                        end
                    end else if (hr_fall) begin
                        if (col_cnt != H_LIM) set_short = 1'b1;
                        row_cnt_nx = row_cnt + RCW'(1);
                        if (row_cnt + RCW'(1) == V_LIM) begin
                            state_nx = IDLE;
                            busy_nx  = 1'b0;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (start_frame) begin
            state_nx       = VSYNC;
            frame_start_nx = 1'b1;
            frame_cnt_nx   = frame_cnt + 8'd1;
            busy_nx        = 1'b1;
            row_cnt_nx     = '0;
            col_cnt_nx     = '0;
            phase_nx       = 1'b0;
            col_nx         = '0;
            row_nx         = '0;
            err_long_nx    = 1'b0;
            err_short_nx   = 1'b0;
        end
        // An error detected on the same cycle as a restart survives the clear.
        if (set_long)  err_long_nx  = 1'b1;
        if (set_short) err_short_nx = 1'b1;
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Purpose : directed bench for cam_pixel_capture with a scoreboard of expected luma pixels.
// Latency : expected pixels are stamped with drive cycle + 2 and compared against the observed cycle.
// Backpressure: n/a; two DUT instances (Y_FIRST=1 and 0) share one stimulus stream.
module tb_cam_pixel_capture;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        logic       r;
        int         t;
    } pix_t;
    typedef logic [7:0] bq_t[$];

    logic       pclk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    logic [7:0] pix_data1, pix_data0, frame_cnt1, frame_cnt0;
    logic       pix_valid1, pix_valid0, frame_start1, frame_start0;
    logic [1:0] col1, col0;
    logic [0:0] row1, row0;
    logic       busy1, busy0, err_long1, err_long0, err_short1, err_short0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fs_cnt1 = 0;
    int   fs_cnt0 = 0;
    int   pc1, pc0, cur_row;
    logic phase;
    pix_t exp1[$], exp0[$], obs1[$], obs0[$];
    pix_t m1, m0;
    bq_t  line8, line10, line6, line4;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc = cyc + 1;

    cam_pixel_capture #(.H_RES(4), .V_RES(2), .Y_FIRST(1'b1)) dut_y1 (
        .pclk(pclk), .reset(reset), .enable(enable),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data1), .pix_valid(pix_valid1), .frame_start(frame_start1),
        .col(col1), .row(row1), .frame_cnt(frame_cnt1), .busy(busy1),
        .err_long(err_long1), .err_short(err_short1)
    );

    cam_pixel_capture #(.H_RES(4), .V_RES(2), .Y_FIRST(1'b0)) dut_y0 (
        .pclk(pclk), .reset(reset), .enable(enable),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data0), .pix_valid(pix_valid0), .frame_start(frame_start0),
        .col(col0), .row(row0), .frame_cnt(frame_cnt0), .busy(busy0),
        .err_long(err_long0), .err_short(err_short0)
    );

    // Output monitor: records observed pixels and frame_start pulses away from the active edge.
    always @(negedge pclk) begin
        if (pix_valid1) begin
            m1.d = pix_data1; m1.c = col1; m1.r = row1[0]; m1.t = cyc;
            obs1.push_back(m1);
        end
        if (pix_valid0) begin
            m0.d = pix_data0; m0.c = col0; m0.r = row0[0]; m0.t = cyc;
            obs0.push_back(m0);
        end
        if (frame_start1) fs_cnt1 = fs_cnt1 + 1;
        if (frame_start0) fs_cnt0 = fs_cnt0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks = checks + 1;
        assert (got === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge pclk);
        #1;
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
    endtask

    task automatic vs_pulse();
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic start_line();
        phase = 1'b0;
        pc1 = 0;
        pc0 = 0;
    endtask

    // Byte 0 of each pair is luma for Y_FIRST=1, byte 1 for Y_FIRST=0; at most 4 pixels per line.
    task automatic send_bytes(input bq_t b, input bit expect_pix);
        pix_t e;
        foreach (b[i]) begin
            drive(1'b0, 1'b1, b[i]);
            if (expect_pix) begin
                e.d = b[i]; e.r = cur_row[0]; e.t = cyc + 2;
                if (phase == 1'b0 && pc1 < 4) begin
                    e.c = pc1[1:0]; exp1.push_back(e); pc1 = pc1 + 1;
                end
                if (phase == 1'b1 && pc0 < 4) begin
                    e.c = pc0[1:0]; exp0.push_back(e); pc0 = pc0 + 1;
                end
            end
            phase = ~phase;
        end
    endtask

    task automatic end_line();
        repeat (4) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic line(input bq_t b, input bit expect_pix);
        start_line();
        send_bytes(b, expect_pix);
        end_line();
    endtask

    task automatic drain();
        pix_t e, o;
        repeat (4) @(posedge pclk);
        #1;
        check("npix_y1", obs1.size(), exp1.size());
        check("npix_y0", obs0.size(), exp0.size());
        while (exp1.size() > 0 && obs1.size() > 0) begin
            e = exp1.pop_front(); o = obs1.pop_front();
            check("y1_data", o.d, e.d);
            check("y1_col", o.c, e.c);
            check("y1_row", o.r, e.r);
            check("y1_cycle", o.t, e.t);
        end
        while (exp0.size() > 0 && obs0.size() > 0) begin
            e = exp0.pop_front(); o = obs0.pop_front();
            check("y0_data", o.d, e.d);
            check("y0_col", o.c, e.c);
            check("y0_row", o.r, e.r);
            check("y0_cycle", o.t, e.t);
        end
        exp1.delete(); obs1.delete(); exp0.delete(); obs0.delete();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
        line8  = '{8'd10, 8'd80, 8'd20, 8'd81, 8'd30, 8'd82, 8'd40, 8'd83};
        line10 = '{8'd11, 8'd90, 8'd12, 8'd91, 8'd13, 8'd92, 8'd14, 8'd93, 8'd15, 8'd94};
        line6  = '{8'd21, 8'd60, 8'd22, 8'd61, 8'd23, 8'd62};
        line4  = '{8'd10, 8'd80, 8'd20, 8'd81};
        cur_row = 0;

        // Reset state
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_y1", {pix_data1, pix_valid1, frame_start1, col1, row1, frame_cnt1, busy1, err_long1, err_short1}, 0);
        check("rst_y0", {pix_data0, pix_valid0, frame_start0, col0, row0, frame_cnt0, busy0, err_long0, err_short0}, 0);
        reset = 1'b1;

        // Activity while disabled: nothing captured
        vs_pulse();
        line(line8, 1'b0);
        drain();
        check("idle_busy", busy1, 0);
        check("idle_fcnt", frame_cnt1, 0);
        check("idle_fs", fs_cnt1, 0);

        // Nominal two-line frame
        enable = 1'b1;
        vs_pulse();
        check("nom_fs", fs_cnt1, 1);
        check("nom_fs_y0", fs_cnt0, 1);
        check("nom_busy", busy1, 1);
        check("nom_fcnt", frame_cnt1, 1);
        cur_row = 0; line(line8, 1'b1); drain();
        check("nom_busy_mid", busy1, 1);
        check("nom_errs", {err_long1, err_short1, err_long0, err_short0}, 0);
        cur_row = 1; line(line8, 1'b1); drain();
        check("nom_busy_end", {busy1, busy0}, 0);
        check("nom_errs_end", {err_long1, err_short1, err_long0, err_short0}, 0);

        // Long line then short line
        vs_pulse();
        check("ls_fcnt", frame_cnt1, 2);
        cur_row = 0; line(line10, 1'b1); drain();
        check("long_err", {err_long1, err_long0}, 2'b11);
        check("long_noshort", err_short1, 0);
        cur_row = 1; line(line6, 1'b1); drain();
        check("short_err", {err_short1, err_short0}, 2'b11);
        check("short_long_sticky", err_long1, 1);
        check("short_busy", busy1, 0);

        // vsync rising mid-line restarts the frame
        vs_pulse();
        check("mid_fcnt0", frame_cnt1, 3);
        check("mid_errclr", {err_long1, err_short1}, 0);
        cur_row = 0; start_line();
        send_bytes(line4, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 8'd99);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
        drain();
        check("mid_err_short", err_short1, 1);
        check("mid_err_long", err_long1, 0);
        check("mid_fcnt", frame_cnt1, 4);
        check("mid_fs", fs_cnt1, 4);
        check("mid_busy", busy1, 1);
        cur_row = 0; line(line8, 1'b1); drain();
        cur_row = 1; line(line8, 1'b1); drain();
        check("mid_done", busy1, 0);
        check("mid_sticky", err_short1, 1);

        // vsync and href together: byte ignored
        repeat (4) drive(1'b1, 1'b1, 8'd55);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
        drain();
        check("vh_fcnt", frame_cnt1, 5);
        check("vh_fs", fs_cnt1, 5);

        // enable dropped mid-frame: frame completes, next vsync ignored
        cur_row = 0; line(line8, 1'b1); drain();
        enable = 1'b0;
        cur_row = 1; line(line8, 1'b1); drain();
        check("en_busy", busy1, 0);
        check("en_errs", {err_long1, err_short1}, 0);
        vs_pulse();
        check("en_fs", fs_cnt1, 5);
        check("en_fcnt", frame_cnt1, 5);
        check("en_idle_busy", busy1, 0);
        cur_row = 0; line(line8, 1'b0); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Camera-side front end that sits directly upstream of the DVS/CDMA stage.
- Samples the raw OV7670-style byte stream (vsync, href, 8-bit data, two bytes per pixel, YUV422) on pclk.
- Extracts the luma byte of each pixel and emits it as a one-cycle-strobed pixel with row/column coordinates.
- Outputs map 1:1 onto the downstream pix_data / write_enable_in / vsync inputs.

Parameters:
- H_RES, 320, active pixels per line.
- V_RES, 240, active lines per frame.
- Y_FIRST, 1, 1 = luma is the first byte of each pair; 0 = luma is the second byte.

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; sampled only at frame start.
- cam_vsync  in  1  camera vsync, active high.
- cam_href  in  1  camera href, active high.
- cam_data  in  8  camera byte bus.
- pix_data  out  8  luma of current pixel.
- pix_valid  out  1  one-cycle strobe; drives downstream write_enable_in.
- frame_start  out  1  one-cycle pulse at start of a captured frame.
- col  out  9  column of pix_data, 0..H_RES-1.
- row  out  8  row of pix_data, 0..V_RES-1.
- frame_cnt  out  8  captured-frame counter, wraps 255->0.
- busy  out  1  high while a frame is being captured.
- err_long  out  1  sticky: a line exceeded H_RES pixels.
- err_short  out  1  sticky: a line ended with fewer than H_RES pixels, or vsync arrived mid-line.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM in IDLE, byte phase 0, all counters 0, input registers 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once on each rising edge of pclk. All logic below acts on these registered copies (vs_r, hr_r, d_r).
- Edge detect: vs_rise = vs_r & ~vs_r_d.
- FSM states:
  - IDLE: waits for vs_rise with enable=1, then goes to VSYNC. Asserts frame_start for 1 cycle, clears row/col, increments frame_cnt, sets busy=1.
  - VSYNC: waits for vs_r=0, then goes to ACTIVE.
  - ACTIVE: processes bytes while hr_r=1.
    - Each rising edge of hr_r: clear col, clear phase.
    - Each falling edge of hr_r: if col != H_RES, set err_short. Then row++.
    - When row reaches V_RES at an href falling edge: go to IDLE, busy=0.
    - vs_rise while in ACTIVE: if hr_r=1 or row < V_RES, set err_short. If enable=1, restart the frame as if from IDLE (frame_start pulse, frame_cnt++); otherwise go to IDLE.
- Byte phase: toggles on every cycle with hr_r=1. The luma byte is phase 0 when Y_FIRST=1, phase 1 otherwise.
- Output on a luma byte with col < H_RES:
  - On the next edge: pix_data <= d_r, pix_valid <= 1, col/row outputs = current coordinates; internal col then increments.
  - pix_valid is 0 on every other cycle.
  - Latency: cam_data luma byte at edge k appears on pix_data at edge k+2.
- Luma byte with col >= H_RES: dropped, err_long set, no pix_valid.
- Rows beyond V_RES (frame already ended): ignored while in IDLE.
- Simultaneous vs_r=1 and hr_r=1: vsync has priority; the byte is ignored and no pix_valid is produced.
- enable=0 mid-frame: the current frame completes normally; no new frame starts until enable=1 at a subsequent vs_rise.
- Sticky error flags clear only on reset or on frame_start.
- Widths: col 9 bits and row 8 bits cover the defaults; the implementation must size them as clog2(H_RES) and clog2(V_RES).

Decomposition:
- Shared package cam_pkg holds:
  - FSM state enum (IDLE, VSYNC, ACTIVE);
  - default H_RES/V_RES constants, shared with the DVS/CDMA stage's BRAM address computation.
- Natural sub-module: cam_sync_edge, which registers vsync/href/data and produces the rise/fall pulses.
- Byte-phase, counter and FSM logic stay in the top level.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then toggle bytes with enable=0 -> all outputs 0, busy=0, no pix_valid.
- Nominal line (H_RES=4, V_RES=2, Y_FIRST=1), enable=1:
  - Stimulus: vsync pulse, then href over bytes 10,80,20,81,30,82,40,83.
  - Required: frame_start once; pix_valid 4 times with pix_data 10,20,30,40, col 0..3, row 0, each 2 cycles after its byte.
  - A second identical line gives row=1, after which busy=0.
- Y_FIRST=0 with the same bytes -> pix_data 80,81,82,83.
- Long line: 10 bytes (5 pixels) with H_RES=4 -> 4 pix_valid pulses, err_long=1. Short line: 6 bytes -> 3 pulses, err_short=1.
- vsync rising mid-line with enable=1 -> err_short=1, frame_start pulse, frame_cnt increments, row/col restart at 0.
- vsync and href high together -> no pix_valid. enable dropped mid-frame -> frame completes, next vsync is ignored, frame_cnt unchanged.
